bram_reader_stream: RTL



---
 rtl/disparity_pkg.sv | 13 +
 rtl/bram_reader_stream_if.sv | 28 ++
 rtl/scfifo_wrapper.sv | 56 +++++
 rtl/bram_reader_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/disparity_pkg.sv
// Shared types for the disparity BRAM frame reader.
// Holds the reader FSM state type and the read-latency ceiling.
package disparity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

    localparam int MAX_RD_LATENCY = 3;

endpackage

// File: rtl/bram_reader_stream_if.sv
// BRAM read port plus valid/ready pixel stream of the frame reader.
// master: reader side (drives rd_*, out_*); slave: BRAM + sink side.
interface bram_reader_stream_if #(
    parameter int DATA_WIDTH = 21,
    parameter int ADDR_BITS  = 15,
    parameter int BANK_BITS  = 1
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  rd_en;
    logic [BANK_BITS-1:0]  rd_bank;
    logic [ADDR_BITS-1:0]  rd_address;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output out_data, out_last, out_valid,
        output rd_en, rd_bank, rd_address,
        input  out_ready, rd_data
    );

    modport slave (
        input  out_data, out_last, out_valid,
        input  rd_en, rd_bank, rd_address,
        output out_ready, rd_data
    );
endinterface

// File: rtl/scfifo_wrapper.sv
// Single-clock show-ahead FIFO with synchronous clear.
// Ports: clk, reset_n, sclr, wr_en/wr_data, rd_en/rd_data, empty, used.
module scfifo_wrapper #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sclr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] used
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_rd;

    assign do_rd   = rd_en && (cnt != '0);
    assign rd_data = mem[rp];
    assign empty   = (cnt == '0);
    assign used    = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (sclr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(do_rd);
        end
    end

    // Storage only; pointers above decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
    end

    overflow_chk: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(wr_en && !sclr && !do_rd && cnt == (AW+1)'(DEPTH))
    );

endmodule

// File: rtl/bram_reader_stream.sv
// Streams one frame from a ping-pong BRAM bank to a valid/ready sink.
// Ports: clk, reset_n, start/bank_in, zero_head/tail, abort, idle, frame_done, bus.
module bram_reader_stream
    import disparity_pkg::*;
#(
    parameter int WIDTH      = 120,
    parameter int HEIGHT     = 240,
    parameter int FRAME_SIZE = WIDTH * HEIGHT,
    parameter int ADDR_BITS  = $clog2(FRAME_SIZE),
    parameter int DATA_WIDTH = 21,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BANK_BITS-1:0] bank_in,
    input  logic [ADDR_BITS-1:0] zero_head,
    input  logic [ADDR_BITS-1:0] zero_tail,
    input  logic                 abort,
    output logic                 idle,
    output logic                 frame_done,
    bram_reader_stream_if.master bus
);
    localparam int IFW = $clog2(MAX_RD_LATENCY + 1);
    localparam int UW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_SIZE - 1);
    localparam logic [ADDR_BITS:0]   FS_EXT    = (ADDR_BITS+1)'(FRAME_SIZE);

    reader_state_t         state_q;
    reader_state_t         state_d;
    logic                  pend_q;
    logic [BANK_BITS-1:0]  pend_bank_q;
    logic [BANK_BITS-1:0]  bank_q;
    logic [BANK_BITS-1:0]  launch_bank;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [ADDR_BITS-1:0]  zh_q;
    logic [ADDR_BITS-1:0]  zt_q;
    logic [IFW-1:0]        inflight_q;
    logic                  launch;
    logic                  issue;
    logic                  room;
    logic                  drained;

    logic [RD_LATENCY-1:0] dly_vld;
    logic [ADDR_BITS-1:0]  dly_addr [RD_LATENCY];
    logic [ADDR_BITS-1:0]  ret_addr;
    logic                  ret_vld;
    logic [ADDR_BITS:0]    tail_sum;
    logic                  zero_word;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH:0]   fifo_wdata;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_empty;
    logic [UW-1:0]         fifo_used;

    // Credits: a slot counts as taken from issue until its pop is
    // visible in the registered fill level, so the FIFO cannot overflow.
    assign room = (int'(fifo_used) + int'(inflight_q)) < FIFO_DEPTH;

    assign ret_vld  = dly_vld[RD_LATENCY-1];
    assign ret_addr = dly_addr[RD_LATENCY-1];

    // Last outstanding read returns this cycle: next frame may launch
    // now, since the old zeroing window is still applied to that word.
    assign drained = (inflight_q == IFW'(ret_vld));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        launch_bank = pend_bank_q;
        issue       = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start || pend_q) begin
                        launch      = 1'b1;
                        launch_bank = start ? bank_in : pend_bank_q;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (room) begin
                        issue = 1'b1;
                        if (addr_q == LAST_ADDR) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        if (pend_q) begin
                            launch  = 1'b1;
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            pend_bank_q <= '0;
        end else if (abort) begin
            pend_q <= 1'b0;
        end else if (start && state_q != IDLE) begin
            pend_q      <= 1'b1;
            pend_bank_q <= bank_in;
        end else if (launch) begin
            pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= '0;
            addr_q <= '0;
            zh_q   <= '0;
            zt_q   <= '0;
        end else if (abort) begin
            addr_q <= '0;
        end else if (launch) begin
            bank_q <= launch_bank;
            addr_q <= '0;
            zh_q   <= zero_head;
            zt_q   <= zero_tail;
        end else if (issue && addr_q != LAST_ADDR) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   inflight_q <= '0;
        else if (abort) inflight_q <= '0;
        else            inflight_q <= inflight_q + IFW'(issue) - IFW'(ret_vld);
    end

    // Address travels with the read so zeroing and last use the
    // address that produced the returning word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_vld <= '0;
        end else if (abort) begin
            dly_vld <= '0;
        end else begin
            dly_vld[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) dly_vld[i] <= dly_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dly_addr[0] <= addr_q;
        for (int i = 1; i < RD_LATENCY; i++) dly_addr[i] <= dly_addr[i-1];
    end

    // Widened sum avoids FRAME_SIZE - zero_tail underflowing.
    assign tail_sum  = {1'b0, ret_addr} + {1'b0, zt_q};
    assign zero_word = (ret_addr < zh_q) || (tail_sum >= FS_EXT);

    assign push       = ret_vld && !abort;
    assign fifo_wdata = {ret_addr == LAST_ADDR,
                         zero_word ? {DATA_WIDTH{1'b0}} : bus.rd_data};

    scfifo_wrapper #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .sclr    (abort),
        .wr_en   (push),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .used    (fifo_used)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head[DATA_WIDTH-1:0];
    assign bus.out_last  = bus.out_valid && fifo_head[DATA_WIDTH];
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.rd_en      = issue;
    assign bus.rd_bank    = bank_q;
    assign bus.rd_address = addr_q;

    assign idle = (state_q == IDLE) && !pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   frame_done <= 1'b0;
        else if (abort) frame_done <= 1'b0;
        else            frame_done <= pop && bus.out_last;
    end

endmodule
